// File: rtl/lane_game_if.sv
// Bundle between the game control FSM / display driver and the lane-game datapath.
// i_* signals flow into the datapath, o_* signals flow out of it.
interface lane_game_if #(
  parameter int LANES   = 4,
  parameter int ROWS    = 32,
  parameter int SCORE_W = 8
);
  logic                    i_run;
  logic                    i_btn_left;
  logic                    i_btn_right;
  logic [1:0]              i_speed;
  logic [LANES-1:0]        o_player_pos;
  logic [SCORE_W-1:0]      o_score;
  logic [2:0]              o_lives;
  logic                    o_hit;
  logic                    o_collect;
  logic                    o_step;
  logic                    o_invulnerable;
  logic                    o_game_over;
  logic [ROWS*LANES-1:0]   o_map_obstacle;
  logic [ROWS*LANES-1:0]   o_map_objective;

  modport master (
    output i_run, i_btn_left, i_btn_right, i_speed,
    input  o_player_pos, o_score, o_lives, o_hit, o_collect, o_step,
           o_invulnerable, o_game_over, o_map_obstacle, o_map_objective
  );

  modport slave (
    input  i_run, i_btn_left, i_btn_right, i_speed,
    output o_player_pos, o_score, o_lives, o_hit, o_collect, o_step,
           o_invulnerable, o_game_over, o_map_obstacle, o_map_objective
  );
endinterface

// File: rtl/lane_game_datapath.sv
// Lane-dodging game datapath: scrolling obstacle/objective map, player movement,
// lives with post-hit invulnerability, saturating score. Requires ROWS >= 2.
module lane_game_datapath #(
  parameter int          LANES            = 4,
  parameter int          ROWS             = 32,
  parameter int          HIT_ROWS         = 2,
  parameter int          BASE_PERIOD      = 250000,
  parameter int          OBSTACLE_PERIOD  = 40,
  parameter int          OBJECTIVE_PERIOD = 90000,
  parameter int          SCORE_PERIOD     = 240,
  parameter int          OBJ_BONUS        = 4,
  parameter int          SCORE_W          = 8,
  parameter int          LIVES            = 3,
  parameter int          INVULN_STEPS     = 8,
  parameter int          WRAP             = 0,
  parameter logic [15:0] SEED             = 16'hACE1
) (
  input  logic       clock,
  input  logic       reset,
  lane_game_if.slave io_bus
);
  localparam int LW  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int NB  = ROWS * LANES;
  localparam int CW  = $clog2(4 * BASE_PERIOD + 1);
  localparam int OW  = (OBSTACLE_PERIOD > 1) ? $clog2(OBSTACLE_PERIOD) : 1;
  localparam int JW  = (OBJECTIVE_PERIOD > 1) ? $clog2(OBJECTIVE_PERIOD) : 1;
  localparam int SCW = (SCORE_PERIOD > 1) ? $clog2(SCORE_PERIOD) : 1;
  localparam int IW  = $clog2(INVULN_STEPS + 1);
  localparam int SX  = SCORE_W + 8;

  localparam logic [CW-1:0]      LIM0     = CW'(4 * BASE_PERIOD - 1);
  localparam logic [CW-1:0]      LIM1     = CW'(3 * BASE_PERIOD - 1);
  localparam logic [CW-1:0]      LIM2     = CW'(2 * BASE_PERIOD - 1);
  localparam logic [CW-1:0]      LIM3     = CW'(BASE_PERIOD - 1);
  localparam logic [LANES-1:0]   POS_LEFT = LANES'(1) << (LANES - 1);
  localparam logic [LANES-1:0]   POS_RGT  = LANES'(1);
  localparam logic [SCORE_W-1:0] SMAX     = '1;

  logic [15:0]        r_lfsr;
  logic               r_btn_l_q, r_btn_r_q, r_edge_l, r_edge_r;
  logic [LANES-1:0]   r_pos;
  logic [CW-1:0]      r_clk_cnt;
  logic               r_step;
  logic [OW-1:0]      r_obs_cnt;
  logic [JW-1:0]      r_obj_cnt;
  logic               r_obj_pend;
  logic [SCW-1:0]     r_score_cnt;
  logic [NB-1:0]      r_map_ob, r_map_oj;
  logic [IW-1:0]      r_inv_cnt;
  logic [2:0]         r_lives;
  logic               r_game_over;
  logic [SCORE_W-1:0] r_score;
  logic               r_hit, r_collect;

  logic               w_active, w_fire, w_eval, w_invuln;
  logic               w_ob_hit, w_ob_get, w_do_hit, w_do_get;
  logic               w_obs_tc, w_obj_set, w_surv;
  logic [CW-1:0]      w_limit;
  logic [LW-1:0]      w_lane_a, w_lane_b;
  logic [LANES-1:0]   w_ob_row, w_oj_row, w_pos_n;
  logic [NB-1:0]      w_win, w_oj_clr;
  logic [SX-1:0]      w_sum;
  logic [SCORE_W-1:0] w_score_n;

  assign w_active  = io_bus.i_run & ~r_game_over;
  assign w_fire    = w_active & (r_clk_cnt >= w_limit);
  assign w_eval    = w_active & ~r_step;
  assign w_invuln  = (r_inv_cnt != '0);
  assign w_ob_hit  = |(r_map_ob & w_win);
  assign w_ob_get  = |(r_map_oj & w_win);
  assign w_do_hit  = w_eval & w_ob_hit & ~w_invuln;
  assign w_do_get  = w_eval & w_ob_get;
  assign w_obs_tc  = (r_obs_cnt == OW'(OBSTACLE_PERIOD - 1));
  assign w_obj_set = (r_obj_cnt == JW'(OBJECTIVE_PERIOD - 1));
  assign w_surv    = w_fire & (r_score_cnt == SCW'(SCORE_PERIOD - 1));
  // Objective lane sits half the lane count away, so it never collides with the obstacle lane.
  assign w_lane_a  = r_lfsr[LW-1:0];
  assign w_lane_b  = w_lane_a + LW'(LANES / 2);
  assign w_ob_row  = w_obs_tc ? (LANES'(1) << w_lane_a) : '0;
  assign w_oj_row  = r_obj_pend ? (LANES'(1) << w_lane_b) : '0;
  assign w_oj_clr  = w_do_get ? (r_map_oj & ~w_win) : r_map_oj;
  assign w_sum     = SX'(r_score) + (w_do_get ? SX'(OBJ_BONUS) : SX'(0)) + (w_surv ? SX'(1) : SX'(0));
  assign w_score_n = (w_sum > SX'(SMAX)) ? SMAX : w_sum[SCORE_W-1:0];

  always_comb begin
    w_limit = LIM3;
    case (io_bus.i_speed)
      2'd0:    w_limit = LIM0;
      2'd1:    w_limit = LIM1;
      2'd2:    w_limit = LIM2;
      default: w_limit = LIM3;
    endcase
  end

  always_comb begin
    w_win = '0;
    for (int r = 0; r < HIT_ROWS; r++) w_win[r*LANES +: LANES] = r_pos;
  end

  always_comb begin
    w_pos_n = r_pos;
    if (r_edge_l & ~r_edge_r) begin
      if (r_pos[LANES-1]) w_pos_n = (WRAP != 0) ? POS_RGT : r_pos;
      else                w_pos_n = r_pos << 1;
    end else if (r_edge_r & ~r_edge_l) begin
      if (r_pos[0]) w_pos_n = (WRAP != 0) ? POS_LEFT : r_pos;
      else          w_pos_n = r_pos >> 1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_lfsr <= SEED;
    else       r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_btn_l_q   <= 1'b0;
      r_btn_r_q   <= 1'b0;
      r_edge_l    <= 1'b0;
      r_edge_r    <= 1'b0;
      r_pos       <= POS_LEFT;
      r_clk_cnt   <= '0;
      r_step      <= 1'b0;
      r_obs_cnt   <= '0;
      r_obj_cnt   <= '0;
      r_obj_pend  <= 1'b0;
      r_score_cnt <= '0;
      r_map_ob    <= '0;
      r_map_oj    <= '0;
      r_inv_cnt   <= '0;
      r_lives     <= 3'(LIVES);
      r_game_over <= 1'b0;
      r_score     <= '0;
      r_hit       <= 1'b0;
      r_collect   <= 1'b0;
    end else begin
      r_hit     <= w_do_hit;
      r_collect <= w_do_get;
      r_step    <= w_fire;
      if (w_active) begin
        r_btn_l_q <= io_bus.i_btn_left;
        r_btn_r_q <= io_bus.i_btn_right;
        r_edge_l  <= io_bus.i_btn_left & ~r_btn_l_q;
        r_edge_r  <= io_bus.i_btn_right & ~r_btn_r_q;
        r_pos     <= w_pos_n;
        r_clk_cnt <= w_fire ? '0 : r_clk_cnt + CW'(1);
        r_obj_cnt <= w_obj_set ? '0 : r_obj_cnt + JW'(1);
        // A request raised in a consuming step cycle survives for the next step.
        if (w_obj_set)   r_obj_pend <= 1'b1;
        else if (w_fire) r_obj_pend <= 1'b0;
        if (w_fire) begin
          r_obs_cnt   <= w_obs_tc ? '0 : r_obs_cnt + OW'(1);
          r_score_cnt <= (r_score_cnt == SCW'(SCORE_PERIOD - 1)) ? '0 : r_score_cnt + SCW'(1);
          r_map_ob    <= {w_ob_row, r_map_ob[NB-1:LANES]};
          r_map_oj    <= {w_oj_row, w_oj_clr[NB-1:LANES]};
        end else begin
          r_map_oj    <= w_oj_clr;
        end
        if (w_do_hit) begin
          r_lives     <= r_lives - 3'd1;
          r_inv_cnt   <= IW'(INVULN_STEPS);
          r_game_over <= (r_lives == 3'd1);
        end else if (w_fire && w_invuln) begin
          r_inv_cnt   <= r_inv_cnt - IW'(1);
        end
        r_score <= w_score_n;
      end
    end
  end

  assign io_bus.o_player_pos    = r_pos;
  assign io_bus.o_score         = r_score;
  assign io_bus.o_lives         = r_lives;
  assign io_bus.o_hit           = r_hit;
  assign io_bus.o_collect       = r_collect;
  assign io_bus.o_step          = r_step;
  assign io_bus.o_invulnerable  = w_invuln;
  assign io_bus.o_game_over     = r_game_over;
  assign io_bus.o_map_obstacle  = r_map_ob;
  assign io_bus.o_map_objective = r_map_oj;
endmodule

// File: tb/tb_lane_game_datapath.sv
// Bench for lane_game_datapath: lane-index game model checked every cycle,
// directed literal checks on timing, movement and wrap, then randomized play.
module tb_lane_game_datapath;
  localparam int L = 4, R = 8, H = 2, BP = 4, OBP = 2, OJP = 10, SP = 5;
  localparam int BON = 4, SW = 4, LV = 3, INV = 3;
  localparam int SEEDV = 16'hACE1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic run = 1'b0, bl = 1'b0, br = 1'b0;
  logic [1:0] spd = 2'd3;
  always #5 clock = ~clock;

  lane_game_if #(.LANES(L), .ROWS(R), .SCORE_W(SW)) bus ();
  lane_game_if #(.LANES(L), .ROWS(R), .SCORE_W(SW)) bus_w ();
  assign bus.i_run = run;     assign bus.i_btn_left = bl;
  assign bus.i_btn_right = br; assign bus.i_speed = spd;
  assign bus_w.i_run = run;   assign bus_w.i_btn_left = bl;
  assign bus_w.i_btn_right = br; assign bus_w.i_speed = spd;

  lane_game_datapath #(.LANES(L), .ROWS(R), .HIT_ROWS(H), .BASE_PERIOD(BP),
    .OBSTACLE_PERIOD(OBP), .OBJECTIVE_PERIOD(OJP), .SCORE_PERIOD(SP), .OBJ_BONUS(BON),
    .SCORE_W(SW), .LIVES(LV), .INVULN_STEPS(INV), .WRAP(0), .SEED(16'hACE1))
    dut (.clock(clock), .reset(reset), .io_bus(bus.slave));

  lane_game_datapath #(.LANES(L), .ROWS(R), .HIT_ROWS(H), .BASE_PERIOD(BP),
    .OBSTACLE_PERIOD(OBP), .OBJECTIVE_PERIOD(OJP), .SCORE_PERIOD(SP), .OBJ_BONUS(BON),
    .SCORE_W(SW), .LIVES(LV), .INVULN_STEPS(INV), .WRAP(1), .SEED(16'hACE1))
    dut_w (.clock(clock), .reset(reset), .io_bus(bus_w.slave));

  int n_pass = 0, n_total = 0;

  // Model state: lanes as indices (L-1 = leftmost), -1 for an empty row.
  int m_pos, m_pl, m_pr, m_el, m_er, m_cc, m_step, m_lfsr, m_oc, m_jc, m_pend;
  int m_ob[R], m_oj[R];
  int m_inv, m_lives, m_go, m_score, m_sc, m_hit, m_col;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_pos = L - 1; m_pl = 0; m_pr = 0; m_el = 0; m_er = 0; m_cc = 0; m_step = 0;
    m_lfsr = SEEDV; m_oc = 0; m_jc = 0; m_pend = 0; m_inv = 0; m_lives = LV;
    m_go = 0; m_score = 0; m_sc = 0; m_hit = 0; m_col = 0;
    for (int r = 0; r < R; r++) begin m_ob[r] = -1; m_oj[r] = -1; end
  endtask

  task automatic model_next();
    int fb, a, newpos, sum;
    bit hitnow, getnow, fire, setp, obsf, surv, ovl_ob, ovl_oj;
    fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
    a = m_lfsr % L;
    m_lfsr = ((m_lfsr << 1) | fb) & 'hFFFF;
    if (!(run && m_go == 0)) begin
      m_hit = 0; m_col = 0; m_step = 0;
    end else begin
      ovl_ob = 0; ovl_oj = 0;
      for (int r = 0; r < H; r++) begin
        if (m_ob[r] == m_pos) ovl_ob = 1;
        if (m_oj[r] == m_pos) ovl_oj = 1;
      end
      hitnow = (m_step == 0) && ovl_ob && (m_inv == 0);
      getnow = (m_step == 0) && ovl_oj;
      fire = (m_cc >= BP * (4 - int'(spd)) - 1);
      m_cc = fire ? 0 : m_cc + 1;
      newpos = m_pos;
      if (m_el != 0 && m_er == 0 && m_pos < L - 1) newpos = m_pos + 1;
      if (m_er != 0 && m_el == 0 && m_pos > 0) newpos = m_pos - 1;
      m_el = (bl && m_pl == 0); m_pl = bl;
      m_er = (br && m_pr == 0); m_pr = br;
      setp = (m_jc == OJP - 1);
      m_jc = setp ? 0 : m_jc + 1;
      if (getnow) for (int r = 0; r < H; r++) if (m_oj[r] == m_pos) m_oj[r] = -1;
      surv = 0;
      if (fire) begin
        obsf = (m_oc == OBP - 1); m_oc = (m_oc + 1) % OBP;
        surv = (m_sc == SP - 1);  m_sc = (m_sc + 1) % SP;
        for (int r = 0; r < R - 1; r++) begin m_ob[r] = m_ob[r+1]; m_oj[r] = m_oj[r+1]; end
        m_ob[R-1] = obsf ? a : -1;
        m_oj[R-1] = (m_pend != 0) ? (a + L / 2) % L : -1;
        if (m_inv > 0) m_inv--;
      end
      m_pend = setp ? 1 : (fire ? 0 : m_pend);
      if (hitnow) begin
        m_lives--; m_inv = INV;
        if (m_lives == 0) m_go = 1;
      end
      sum = m_score + (getnow ? BON : 0) + (surv ? 1 : 0);
      m_score = (sum > (1 << SW) - 1) ? (1 << SW) - 1 : sum;
      m_hit = hitnow; m_col = getnow; m_step = fire; m_pos = newpos;
    end
  endtask

  task automatic compare();
    logic [R*L-1:0] eob, eoj;
    eob = '0; eoj = '0;
    for (int r = 0; r < R; r++) begin
      if (m_ob[r] >= 0) eob[r*L + m_ob[r]] = 1'b1;
      if (m_oj[r] >= 0) eoj[r*L + m_oj[r]] = 1'b1;
    end
    chk("pos", bus.o_player_pos, 1 << m_pos);
    chk("score", bus.o_score, m_score);
    chk("lives", bus.o_lives, m_lives);
    chk("hit", bus.o_hit, m_hit);
    chk("collect", bus.o_collect, m_col);
    chk("step", bus.o_step, m_step);
    chk("invulnerable", bus.o_invulnerable, (m_inv != 0) ? 1 : 0);
    chk("game_over", bus.o_game_over, m_go);
    chk("map_obstacle", bus.o_map_obstacle, eob);
    chk("map_objective", bus.o_map_objective, eoj);
  endtask

  task automatic cyc();
    model_next();
    @(posedge clock);
    @(negedge clock);
    compare();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    #1;
    model_reset();
    compare();
    chk("rst_pos", bus.o_player_pos, 4'b1000);
    chk("rst_lives", bus.o_lives, 3);
    chk("rst_score", bus.o_score, 0);
    chk("rst_map_ob", bus.o_map_obstacle, 0);
    chk("rst_map_oj", bus.o_map_objective, 0);
    repeat (n) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_step(input int budget, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (bus.o_step !== 1'b1 && n < budget);
    if (bus.o_step !== 1'b1) n = -1;
  endtask

  task automatic press(input bit left);
    if (left) bl = 1'b1; else br = 1'b1;
    cyc();
    bl = 1'b0; br = 1'b0;
    cyc();
    cyc();
  endtask

  initial begin
    int n, cnt, len;
    model_reset();
    @(negedge clock);
    do_reset(2);
    run = 1'b1; spd = 2'd3;

    wait_step(50, n);  chk("first_step_latency", n, 4);
    spd = 2'd0;
    wait_step(50, n);  chk("speed0_interval", n, 16);
    chk("step2_row7_obstacle", $countones(bus.o_map_obstacle[R*L-1 -: L]), 1);
    spd = 2'd3;
    wait_step(50, n);  chk("speed3_interval", n, 4);
    chk("step3_row7_obstacle", $countones(bus.o_map_obstacle[R*L-1 -: L]), 0);
    spd = 2'd0;
    repeat (10) cyc();
    spd = 2'd3;
    wait_step(50, n);  chk("speed_up_past_limit", n, 1);

    do_reset(1);
    wait_step(50, n);  chk("post_reset_step", n, 4);

    press(1'b1); chk("left_at_edge", bus.o_player_pos, 4'b1000);
                 chk("wrap_left", bus_w.o_player_pos, 4'b0001);
    press(1'b0); chk("right1", bus.o_player_pos, 4'b0100);
                 chk("wrap_right", bus_w.o_player_pos, 4'b1000);
    press(1'b0); chk("right2", bus.o_player_pos, 4'b0010);
    press(1'b0); chk("right3", bus.o_player_pos, 4'b0001);
    press(1'b0); chk("right_at_edge", bus.o_player_pos, 4'b0001);

    run = 1'b0; cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (bus.o_step === 1'b1) cnt++;
    end
    chk("run_low_steps", cnt, 0);
    run = 1'b1;

    for (int ep = 0; ep < 40; ep++) begin
      len = $urandom_range(100, 400);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 3) == 0) bl = ~bl;
        if ($urandom_range(0, 3) == 0) br = ~br;
        run = ($urandom_range(0, 19) != 0);
        if ($urandom_range(0, 49) == 0) spd = 2'($urandom_range(0, 3));
        cyc();
      end
      do_reset($urandom_range(1, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
